// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scan scheduler for a time-multiplexed seven-segment display.
// Each digit slot is DIV cycles long. The first BLANK cycles of a slot keep all
// anodes dark, which prevents ghosting. The remaining cycles drive the selected anode.
// At a frame boundary the scan can be frozen (HOLD) so the display data can be updated.
// Optional feature macro: DISP_BRIGHTNESS_PWM_EN adds a 4-bit duty input and
// PWM-gates the anode during the drive phase.
// Handshake: upd_req is a level request, sampled only on the frame_tick cycle.
// upd_ack is high for exactly the cycles in which the scan is frozen. The
// requester keeps upd_req high for as long as it needs the freeze.
module disp_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 125000,
    parameter int BLANK      = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS-1:0]         en_mask,
    input  logic                          upd_req,
`ifdef DISP_BRIGHTNESS_PWM_EN
    input  logic [3:0]                    duty,
`endif
    output logic                          upd_ack,
    output logic [$clog2(NUM_DIGITS)-1:0] sel,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          slot_tick,
    output logic                          frame_tick,
    output logic [1:0]                    dbg_state,
    output logic [$clog2(DIV)-1:0]        dbg_cnt
);

    localparam int SW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);
    localparam logic [SW-1:0] SEL_LAST  = SW'(NUM_DIGITS - 1);

    // Elaboration-time parameter checks
    if (BLANK < 1 || BLANK >= DIV) begin : g_bad_blank
        $error("disp_scan_ctrl: BLANK must satisfy 1 <= BLANK < DIV");
    end
    if (DIV < 4 || DIV > (1 << 24)) begin : g_bad_div
        $error("disp_scan_ctrl: DIV must be within 4..2^24");
    end
    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("disp_scan_ctrl: NUM_DIGITS must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         sel_q, sel_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  upd_ack_q, upd_ack_d;
    logic                  slot_tick_q, slot_tick_d;
    logic                  frame_tick_q, frame_tick_d;

`ifdef DISP_BRIGHTNESS_PWM_EN
    logic [3:0]            pwm_q, pwm_d;
    logic [3:0]            duty_q, duty_d;
`endif

    // State register: slot counter, digit index and scan phase
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            sel_q   <= '0;
`ifdef DISP_BRIGHTNESS_PWM_EN
            pwm_q   <= '0;
            duty_q  <= duty;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
`ifdef DISP_BRIGHTNESS_PWM_EN
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
`endif
        end
    end

    // Next-state logic: advance within the slot, step digits, freeze at frame end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (state_q == ST_HOLD) begin
            cnt_d = '0;
            sel_d = '0;
            if (!upd_req) begin
                state_d = ST_BLANK;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            if (sel_q == SEL_LAST) begin
                sel_d = '0;
                if (upd_req) begin
                    state_d = ST_HOLD;
                end
            end else begin
                sel_d = sel_q + SW'(1);
            end
        end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_d >= BLANK_END) ? ST_DRIVE : ST_BLANK;
        end
    end

    // Output logic: outputs are computed from the next state so the registered
    // outputs line up with the cycle the state describes
    always_comb begin
        an_d         = '1;
        upd_ack_d    = (state_d == ST_HOLD);
        slot_tick_d  = (state_d != ST_HOLD) && (cnt_d == CNT_LAST);
        frame_tick_d = slot_tick_d && (sel_d == SEL_LAST);
`ifdef DISP_BRIGHTNESS_PWM_EN
        // The PWM phase restarts at the first drive cycle of each slot.
        // Duty is latched whenever a slot (or a hold cycle) begins.
        pwm_d  = '0;
        duty_d = (cnt_d == '0) ? duty : duty_q;
        if (state_d == ST_DRIVE && state_q == ST_DRIVE) begin
            pwm_d = pwm_q + 4'd1;
        end
        if (state_d == ST_DRIVE && en_mask[sel_d] && (pwm_d < duty_d)) begin
            an_d[sel_d] = 1'b0;
        end
`else
        if (state_d == ST_DRIVE && en_mask[sel_d]) begin
            an_d[sel_d] = 1'b0;
        end
`endif
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q         <= '1;
            upd_ack_q    <= 1'b0;
            slot_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            upd_ack_q    <= upd_ack_d;
            slot_tick_q  <= slot_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign upd_ack    = upd_ack_q;
    assign slot_tick  = slot_tick_q;
    assign frame_tick = frame_tick_q;
    assign sel        = sel_q;
    assign dbg_state  = state_q;
    assign dbg_cnt    = cnt_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Testbench for disp_scan_ctrl.
// The reference model tracks the scan as a single time position inside the frame,
// plus a hold flag. Slot, offset and tick expectations come from arithmetic on that
// position. The model pushes one expected observation per cycle into exp_q, and a
// negedge monitor pops each entry and compares it with the DUT outputs.
module tb_disp_scan_ctrl;

    localparam int N = 8;
`ifdef DISP_BRIGHTNESS_PWM_EN
    localparam int DIV   = 40;
    localparam int BLANK = 4;
`else
    localparam int DIV   = 8;
    localparam int BLANK = 2;
`endif
    localparam int SW    = $clog2(N);
    localparam int CW    = $clog2(DIV);
    localparam int FRAME = N * DIV;
    localparam int OW    = 1 + SW + N + 1 + 1 + CW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  en_mask = '1;
    logic          upd_req = 1'b0;
    logic [3:0]    duty = 4'd8;
    logic          upd_ack;
    logic [SW-1:0] sel;
    logic [N-1:0]  an;
    logic          slot_tick;
    logic          frame_tick;
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_cnt;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .en_mask    (en_mask),
        .upd_req    (upd_req),
`ifdef DISP_BRIGHTNESS_PWM_EN
        .duty       (duty),
`endif
        .upd_ack    (upd_ack),
        .sel        (sel),
        .an         (an),
        .slot_tick  (slot_tick),
        .frame_tick (frame_tick),
        .dbg_state  (dbg_state),
        .dbg_cnt    (dbg_cnt)
    );

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    int  m_t    = 0;    // position within the frame, 0..FRAME-1
    bit  m_hold = 1'b0;
    int  m_duty = 0;

    // Model: consume the inputs seen at this edge and predict the next cycle
    always @(posedge clk) begin : model
        logic [N-1:0] an_v;
        int slot;
        int off;
        bit on;
        if (reset) begin
            m_hold = 1'b0;
            m_t    = 0;
        end else if (m_hold) begin
            m_t = 0;
            if (!upd_req) m_hold = 1'b0;
        end else if (m_t == FRAME - 1) begin
            m_t    = 0;
            m_hold = upd_req;
        end else begin
            m_t = m_t + 1;
        end
        if (reset || m_hold || (m_t % DIV) == 0) m_duty = int'(duty);

        if (m_hold) begin
            exp_q.push_back({1'b1, SW'(0), {N{1'b1}}, 1'b0, 1'b0, CW'(0)});
        end else begin
            slot = m_t / DIV;
            off  = m_t % DIV;
            an_v = '1;
            on   = (off >= BLANK) && en_mask[slot];
`ifdef DISP_BRIGHTNESS_PWM_EN
            on = on && (((off - BLANK) % 16) < m_duty);
`endif
            if (on) an_v[slot] = 1'b0;
            exp_q.push_back({1'b0, SW'(slot), an_v, (off == DIV - 1),
                             (m_t == FRAME - 1), CW'(off)});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [OW-1:0] e;
        logic [OW-1:0] got;
        if (exp_q.size() > 0) begin
            cyc = cyc + 1;
            e   = exp_q.pop_front();
            got = {upd_ack, sel, an, slot_tick, frame_tick, dbg_cnt};
            n_cmp = n_cmp + 1;
            if (got !== e) begin
                n_err = n_err + 1;
                $display("FAIL outputs cycle %0d: got ack=%b sel=%0d an=%h st=%b ft=%b cnt=%0d, need ack=%b sel=%0d an=%h st=%b ft=%b cnt=%0d",
                         cyc, upd_ack, sel, an, slot_tick, frame_tick, dbg_cnt,
                         e[OW-1], e[OW-2 -: SW], e[CW+2+N-1 -: N], e[CW+1], e[CW], e[CW-1:0]);
            end
            n_cmp = n_cmp + 1;
            if ($countones(~an) > 1) begin
                n_err = n_err + 1;
                $display("FAIL an_onehot cycle %0d: an=%h, need at most one low bit", cyc, an);
            end
            n_cmp = n_cmp + 1;
            if ((upd_ack || dbg_cnt < CW'(BLANK)) && an !== '1) begin
                n_err = n_err + 1;
                $display("FAIL an_dark cycle %0d: an=%h ack=%b cnt=%0d, need all ones", cyc, an, upd_ack, dbg_cnt);
            end
            n_cmp = n_cmp + 1;
            if (!(int'(sel) < N)) begin
                n_err = n_err + 1;
                $display("FAIL sel_range cycle %0d: sel=%0d, need < %0d", cyc, sel, N);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int budget, input string what);
        int k = 0;
        while (upd_ack !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        n_cmp = n_cmp + 1;
        if (upd_ack !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL %s: upd_ack=%b after %0d cycles, need 1", what, upd_ack, k);
        end
    endtask

    task automatic wait_sel(input int v, input int budget);
        int k = 0;
        while (int'(sel) != v && k < budget) begin
            step(1);
            k++;
        end
        n_cmp = n_cmp + 1;
        if (int'(sel) != v) begin
            n_err = n_err + 1;
            $display("FAIL wait_sel: sel=%0d after %0d cycles, need %0d", sel, k, v);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        en_mask = '1;
        upd_req = 1'b0;
        duty    = 4'd8;
        step(3);
        reset = 1'b0;

        // Full-brightness scan over two frames
        step(2 * FRAME);

        // Two digits masked off
        en_mask = 8'hF5;
        step(FRAME);
        en_mask = '1;

        // Mid-frame request waits for frame end, then a 10-cycle hold
        wait_sel(3, FRAME + 4);
        upd_req = 1'b1;
        wait_ack(FRAME + 4, "grant_mid_frame");
        step(10);
        upd_req = 1'b0;
        step(FRAME + 5);

        // Reset in HOLD, request still high gives a new grant after the restart
        upd_req = 1'b1;
        wait_ack(FRAME + 4, "grant_before_reset");
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);
        wait_ack(FRAME + 4, "grant_after_reset");
        step(4);
        upd_req = 1'b0;
        step(FRAME);

`ifdef DISP_BRIGHTNESS_PWM_EN
        // Brightness levels
        duty = 4'd8;
        step(2 * FRAME);
        duty = 4'd0;
        step(2 * FRAME);
        duty = 4'd15;
        step(FRAME);
        duty = 4'd1;
        step(FRAME);
`endif

        // Random en_mask / upd_req traffic
        for (int i = 0; i < 1000; i++) begin
            en_mask = N'($urandom);
            if ($urandom_range(0, 15) == 0) upd_req = ~upd_req;
`ifdef DISP_BRIGHTNESS_PWM_EN
            if ($urandom_range(0, 31) == 0) duty = 4'($urandom_range(0, 15));
`endif
            step(1);
        end
        upd_req = 1'b0;
        step(FRAME + 4);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Scan scheduler for the 8-digit time-multiplexed seven-segment display.
- Owns the digit-slot timing: selects which digit index the segment datapath decodes, drives the active-low anodes, and inserts an anti-ghosting blank interval at the start of every slot.
- Provides a frame-boundary update handshake, so counter/debounce logic can change display data without tearing a frame.

Parameters:
- NUM_DIGITS, 8: digits scanned; sel width = $clog2(NUM_DIGITS).
- DIV, 125000: clk cycles per digit slot. 100 MHz gives 800 Hz per slot and 100 Hz per frame. Legal range 4..2^24.
- BLANK, 1000: cycles at the start of each slot with all anodes off. Must satisfy 1 <= BLANK < DIV; elaboration assertion on violation.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- en_mask  input  NUM_DIGITS  per-digit enable; 0 keeps that digit dark for its slot.
- upd_req  input  1  level request to freeze the scan for a data update.
- upd_ack  output  1  high while the scan is frozen and data may change.
- sel  output  $clog2(NUM_DIGITS)  current digit index driven to the segment mux/decoder.
- an  output  NUM_DIGITS  anodes, active-low, one-hot-low when driving.
- slot_tick  output  1  1-cycle pulse on the last cycle of every slot.
- frame_tick  output  1  1-cycle pulse on the last cycle of slot NUM_DIGITS-1.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high. All outputs are registered.
- Reset values: sel=0, an=all 1s, upd_ack=0, slot_tick=0, frame_tick=0, cnt=0, state=BLANK.
- Slot counter: cnt counts 0..DIV-1 and wraps to 0.
- State encoding: state is derived from cnt, plus an explicit HOLD state.
  - BLANK (cnt < BLANK): an = all 1s.
  - DRIVE (BLANK <= cnt <= DIV-1): an[sel]=0 if en_mask[sel]=1, otherwise all 1s. All other bits are 1.
  - an reflects en_mask one cycle after en_mask changes; a mid-slot en_mask change takes effect immediately.
- Slot end: in the cycle with cnt=DIV-1, slot_tick=1. On the next edge, sel increments, wrapping NUM_DIGITS-1 -> 0.
- Frame end: frame_tick=1 in the same cycle as slot_tick when sel=NUM_DIGITS-1.
- Disabled digits still consume their full slot. Slots are never skipped, so the frame period is always NUM_DIGITS*DIV.
- Update handshake:
  - upd_req is sampled only at frame end (frame_tick cycle).
  - If upd_req=1 there, enter HOLD on the next edge: an = all 1s, upd_ack=1, sel=0, cnt held at 0, no ticks.
  - HOLD persists while upd_req=1.
  - The first cycle with upd_req=0 in HOLD returns to BLANK: upd_ack=0 on the following edge, and the scan restarts at sel=0, cnt=0.
  - upd_req asserted mid-frame waits for the frame end; upd_ack stays 0 until then.
  - Worst-case grant latency is NUM_DIGITS*DIV cycles.
- Reset mid-operation: any state, including HOLD, returns to reset values on the next edge; upd_ack drops even if upd_req is still high.
- Anode invariant: at most one an bit is 0 in any cycle.

Optional Feature:
- Macro: DISP_BRIGHTNESS_PWM_EN.
- When defined:
  - Adds port duty  input  4  brightness level.
  - A free-running 4-bit pwm counter advances each cycle in DRIVE and resets at each slot start.
  - The driven anode is low only while pwm < duty. duty=0 gives fully dark; duty=15 gives 15/16 on-time.
  - duty is sampled at slot start and held for the slot.
- When undefined: no duty port; the DRIVE-phase anode is low for the whole DRIVE phase.

Test Plan:
Bench parameters: NUM_DIGITS=8, DIV=8, BLANK=2.
1. Reset, then release with en_mask=FF -> cnt 0-1: an=FF; cnt 2-7: an=FE, sel=0; slot_tick at cnt=7; next slot an=FD, sel=1; frame_tick once per 64 cycles, on the sel=7 slot_tick.
2. en_mask=F5 over a full frame -> an stays FF during the slots for sel=1 and sel=3; slot and frame timing unchanged (64 cycles).
3. upd_req=1 asserted at sel=3 -> upd_ack stays 0 until the frame_tick cycle, goes 1 on the next edge with an=FF and sel=0; hold upd_req 10 cycles then drop it -> upd_ack=0 one edge later, scan restarts at sel=0, cnt=0.
4. Reset pulsed while in HOLD with upd_req=1 -> next edge: upd_ack=0, an=FF, sel=0, cnt=0; scan resumes normally after reset deasserts. upd_req still at 1 is sampled again at the first frame_tick, giving a new grant.
5. With DISP_BRIGHTNESS_PWM_EN, DIV=40, BLANK=4, duty=8 -> in each slot's 36-cycle DRIVE phase the anode is low for cycles 0-7 of each 16-cycle pwm window (8+8+4 = 20 cycles); duty=0 -> an=FF for the whole frame.
6. Continuous check over 1000 random en_mask/upd_req cycles -> at most one an bit low; no an low during BLANK or HOLD; sel always in range 0..7.
